// File: rtl/zxuno_regbus_pkg.sv
// Shared constants and FSM encoding for the ZX-UNO extended register bus.
// Port numbers are full 16-bit decodes; REG_COREID is the core-ID string register.
package zxuno_regbus_pkg;

  localparam logic [15:0] ADDR_PORT_C = 16'hFC3B;
  localparam logic [15:0] DATA_PORT_C = 16'hFD3B;
  localparam logic [7:0]  REG_COREID  = 8'hFF;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_ADDR_WR  = 3'd1;
  localparam state_t ST_ADDR_RD  = 3'd2;
  localparam state_t ST_DATA_WR  = 3'd3;
  localparam state_t ST_DATA_RD  = 3'd4;
  localparam state_t ST_WAIT_END = 3'd5;

endpackage

// File: rtl/regbus_rdmux.sv
// Priority read-data mux over the register peripherals: lowest index wins,
// 8'hFF when nobody drives, and a flag when two or more drive together.
module regbus_rdmux #(
  parameter int NUM_DEV = 4
) (
  input  logic [8*NUM_DEV-1:0] dev_dout,
  input  logic [NUM_DEV-1:0]   dev_oe_n,
  output logic [7:0]           mux_dout,
  output logic                 multi
);

  logic found;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the loop can leave a value unassigned and infer a latch.
  always_comb begin
    mux_dout = 8'hFF;
    multi    = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (!dev_oe_n[i]) begin
        if (found) multi = 1'b1;
        else       mux_dout = dev_dout[8*i +: 8];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zxuno_regbus_ctrl.sv
// ZX-UNO register-bus sequencer: decodes the address/data I/O ports, holds the
// register number, generates the peripheral strobes and returns read data.
module zxuno_regbus_ctrl
  import zxuno_regbus_pkg::*;
#(
  parameter int          NUM_DEV   = 4,
  parameter logic [15:0] ADDR_PORT = ADDR_PORT_C,
  parameter logic [15:0] DATA_PORT = DATA_PORT_C
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          cpu_a,
  input  logic                 cpu_iorq_n,
  input  logic                 cpu_m1_n,
  input  logic                 cpu_rd_n,
  input  logic                 cpu_wr_n,
  input  logic [7:0]           cpu_din,
  output logic [7:0]           cpu_dout,
  output logic                 cpu_oe_n,
  output logic [7:0]           zxuno_addr,
  output logic                 zxuno_regrd,
  output logic                 zxuno_regwr,
  output logic                 regaddr_changed,
  input  logic [8*NUM_DEV-1:0] dev_dout,
  input  logic [NUM_DEV-1:0]   dev_oe_n,
  output logic                 err_multi
);

  state_t     state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] dout_q, dout_d;
  logic       oe_n_q, oe_n_d;
  logic       chg_q, chg_d;
  logic       err_q, err_d;

  logic       io_ok, is_rd, is_wr, hit_addr, hit_data;
  logic [7:0] mux_dout;
  logic       multi;

  regbus_rdmux #(.NUM_DEV(NUM_DEV)) u_rdmux (
    .dev_dout (dev_dout),
    .dev_oe_n (dev_oe_n),
    .mux_dout (mux_dout),
    .multi    (multi)
  );

  // Interrupt acknowledge (M1 low) and both strobes low are not accesses.
  assign io_ok    = !cpu_iorq_n && cpu_m1_n && (cpu_rd_n != cpu_wr_n);
  assign is_rd    = io_ok && !cpu_rd_n;
  assign is_wr    = io_ok && !cpu_wr_n;
  assign hit_addr = (cpu_a == ADDR_PORT);
  assign hit_data = (cpu_a == DATA_PORT);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    oe_n_d  = 1'b1;
    chg_d   = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if      (is_wr && hit_addr) state_d = ST_ADDR_WR;
        else if (is_wr && hit_data) state_d = ST_DATA_WR;
        else if (is_rd && hit_addr) state_d = ST_ADDR_RD;
        else if (is_rd && hit_data) state_d = ST_DATA_RD;
      end
      ST_ADDR_WR: begin
        addr_d  = cpu_din;
        chg_d   = 1'b1;
        state_d = ST_WAIT_END;
      end
      ST_DATA_WR: state_d = ST_WAIT_END;
      ST_ADDR_RD: begin
        if (is_rd && hit_addr) begin
          dout_d = addr_q;
          oe_n_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA_RD: begin
        err_d = err_q | multi;
        if (is_rd && hit_data) begin
          dout_d = mux_dout;
          oe_n_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      // Write cycles park here so a long CPU strobe yields a single pulse.
      ST_WAIT_END: if (cpu_iorq_n) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it sits inside the clocked branch; an I/O
  // cycle caught mid-flight is parked in WAIT_END until IORQ rises.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= cpu_iorq_n ? ST_IDLE : ST_WAIT_END;
      addr_q  <= 8'h00;
      dout_q  <= 8'hFF;
      oe_n_q  <= 1'b1;
      chg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      oe_n_q  <= oe_n_d;
      chg_q   <= chg_d;
      err_q   <= err_d;
    end
  end

  assign cpu_dout        = dout_q;
  assign cpu_oe_n        = oe_n_q;
  assign zxuno_addr      = addr_q;
  assign zxuno_regrd     = (state_q == ST_DATA_RD);
  assign zxuno_regwr     = (state_q == ST_DATA_WR);
  assign regaddr_changed = chg_q;
  assign err_multi       = err_q;

endmodule
